// File: rtl/ext_pkg.sv
// Extension-mode encodings and helpers shared by the operand extender.
package ext_pkg;

  localparam logic [2:0] EXT_ZERO   = 3'b000;
  localparam logic [2:0] EXT_SIGN   = 3'b001;
  localparam logic [2:0] EXT_LUI    = 3'b010;
  localparam logic [2:0] EXT_BOFS   = 3'b011;
  localparam logic [2:0] EXT_SEXT_B = 3'b100;
  localparam logic [2:0] EXT_ZEXT_B = 3'b101;

  function automatic logic ext_is_reserved(input logic [2:0] op);
    return (op == 3'b110) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/ext_comb.sv
// Combinational extender: widens an IN_W-bit field to OUT_W bits under a 3-bit mode.
module ext_comb
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       op,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  logic signed [IN_W-1:0]  immS;
  logic signed [7:0]       byteS;
  logic signed [OUT_W-1:0] sextFull;
  logic signed [OUT_W-1:0] sextByte;

  assign immS     = imm;
  assign byteS    = imm[7:0];
  assign sextFull = immS;
  assign sextByte = byteS;

  always_comb begin
    data = '0;
    err  = ext_is_reserved(op);
    case (op)
      EXT_ZERO:   data = {{(OUT_W-IN_W){1'b0}}, imm};
      EXT_SIGN:   data = sextFull;
      EXT_LUI:    data = {imm, {(OUT_W-IN_W){1'b0}}};
      EXT_BOFS:   data = sextFull <<< 2;
      EXT_SEXT_B: data = sextByte;
      EXT_ZEXT_B: data = {{(OUT_W-8){1'b0}}, imm[7:0]};
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered operand extender with valid/ready on both sides and a one-entry skid
// behind the output register, so in_ready never depends combinationally on out_ready.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  // Stage p0: combinational extension of the incoming field
  logic [OUT_W-1:0] extData_p0;
  logic             extErr_p0;

  ext_comb #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) uExt (
    .imm (in_imm),
    .op  (in_op),
    .data(extData_p0),
    .err (extErr_p0)
  );

  // Stage p1: main output register plus skid register
  logic             mainVld_p1;
  logic [OUT_W-1:0] mainData_p1;
  logic [TAG_W-1:0] mainTag_p1;
  logic             mainErr_p1;
  logic             skidVld_p1;
  logic [OUT_W-1:0] skidData_p1;
  logic [TAG_W-1:0] skidTag_p1;
  logic             skidErr_p1;

  logic accept;
  logic drain;
  logic mainFree;
  logic mainLoad;
  logic skidLoad;
  logic mainVldNext;
  logic skidVldNext;

  assign in_ready = !skidVld_p1 && !reset;

  always_comb begin
    accept      = in_valid && in_ready && !flush;
    drain       = mainVld_p1 && out_ready;
    mainFree    = !mainVld_p1 || drain;
    mainLoad    = mainFree && (skidVld_p1 || accept) && !flush;
    skidLoad    = accept && !mainFree;
    mainVldNext = mainVld_p1;
    skidVldNext = skidVld_p1;
    if (mainFree) begin
      mainVldNext = skidVld_p1 || accept;
    end
    if (skidVld_p1) begin
      skidVldNext = !mainFree;
    end else begin
      skidVldNext = skidLoad;
    end
    if (flush) begin
      mainVldNext = 1'b0;
      skidVldNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mainVld_p1 <= 1'b0;
      skidVld_p1 <= 1'b0;
    end else begin
      mainVld_p1 <= mainVldNext;
      skidVld_p1 <= skidVldNext;
    end
  end

  // The visible result must read as zero after reset, so the main payload is cleared too
  always_ff @(posedge clk) begin
    if (reset) begin
      mainData_p1 <= '0;
      mainTag_p1  <= '0;
      mainErr_p1  <= 1'b0;
    end else if (mainLoad) begin
      if (skidVld_p1) begin
        mainData_p1 <= skidData_p1;
        mainTag_p1  <= skidTag_p1;
        mainErr_p1  <= skidErr_p1;
      end else begin
        mainData_p1 <= extData_p0;
        mainTag_p1  <= in_tag;
        mainErr_p1  <= extErr_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (skidLoad) begin
      skidData_p1 <= extData_p0;
      skidTag_p1  <= in_tag;
      skidErr_p1  <= extErr_p0;
    end
  end

  assign out_valid = mainVld_p1;
  assign out_data  = mainData_p1;
  assign out_tag   = mainTag_p1;
  assign out_err   = mainErr_p1;

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: the driver queues expected beats on accept, a
// negedge monitor pops and compares whenever a result beat is consumed.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] curExpData = '0;
  logic        curExpErr = 1'b0;

  ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: extension rules computed with plain integer arithmetic
  function automatic exp_t refExt(input logic [15:0] imm, input logic [2:0] op, input logic [4:0] tag);
    longint s, b;
    exp_t   r;
    s = imm[15] ? longint'(imm) - 65536 : longint'(imm);
    b = imm[7] ? longint'(imm[7:0]) - 256 : longint'(imm[7:0]);
    r.tag = tag;
    r.err = 1'b0;
    case (op)
      3'd0: r.data = 32'(longint'(imm));
      3'd1: r.data = 32'(s);
      3'd2: r.data = 32'(longint'(imm) * 65536);
      3'd3: r.data = 32'(s * 4);
      3'd4: r.data = 32'(b);
      3'd5: r.data = 32'(longint'(imm[7:0]));
      default: begin
        r.data = '0;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBeat(input logic [15:0] imm, input logic [2:0] op, input logic [4:0] tag);
    exp_t e;
    e = refExt(imm, op, tag);
    in_valid   = 1'b1;
    in_imm     = imm;
    in_op      = op;
    in_tag     = tag;
    curExpData = e.data;
    curExpErr  = e.err;
  endtask

  task automatic offer(input logic [15:0] imm, input logic [2:0] op, input logic [4:0] tag);
    bit acc;
    int n;
    n = 0;
    setBeat(imm, op, tag);
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    check("offer_accept", 32'(acc), 32'd1);
  endtask

  // Monitor: compares consumed beats and checks that stalled outputs hold still
  logic        holdPrev = 1'b0;
  logic [31:0] hData;
  logic [4:0]  hTag;
  always @(negedge clk) begin
    exp_t e;
    if (holdPrev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, hData);
      check("hold_tag", 32'(out_tag), 32'(hTag));
    end
    holdPrev = out_valid && !out_ready && !reset && !flush;
    hData    = out_data;
    hTag     = out_tag;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_beat", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_tag", 32'(out_tag), 32'(e.tag));
          check("sb_err", 32'(out_err), 32'(e.err));
        end
      end
      if (in_valid && in_ready) begin
        e.data = curExpData;
        e.tag  = in_tag;
        e.err  = curExpErr;
        sb.push_back(e);
      end
    end
  end

  logic [15:0] t1Imm [6] = '{16'hf13a, 16'hf13a, 16'hf13a, 16'hf13a, 16'h0080, 16'h0080};
  logic [31:0] t1Exp [6] = '{32'h0000f13a, 32'hfffff13a, 32'hf13a0000, 32'hffffc4e8,
                             32'hffffff80, 32'h00000080};

  initial begin
    int vldCount;
    int rdyZero;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(in_ready), 32'd1);
    tick();

    // Test 1: every mode, one cycle latency
    for (int i = 0; i < 6; i++) begin
      setBeat(t1Imm[i], 3'(i), 5'(i + 1));
      curExpData = t1Exp[i];
      curExpErr  = 1'b0;
      tick();
      in_valid = 1'b0;
      check("mode_latency_valid", 32'(out_valid), 32'd1);
      tick();
    end

    // Test 2: reserved op then a normal op
    setBeat(16'h1234, 3'b110, 5'd7);
    curExpData = 32'h0;
    curExpErr  = 1'b1;
    tick();
    check("rsv_err", 32'(out_err), 32'd1);
    setBeat(16'h1234, 3'b001, 5'd8);
    curExpData = 32'h00001234;
    curExpErr  = 1'b0;
    tick();
    in_valid = 1'b0;
    check("rsv_next_err", 32'(out_err), 32'd0);
    tick();

    // Test 3: back-pressure with tags 1..6
    out_ready = 1'b0;
    setBeat(16'($urandom), 3'($urandom_range(0, 5)), 5'd1);
    tick();
    check("bp_ready_one_held", 32'(in_ready), 32'd1);
    setBeat(16'($urandom), 3'($urandom_range(0, 5)), 5'd2);
    tick();
    check("bp_ready_two_held", 32'(in_ready), 32'd0);
    check("bp_tag_stall1", 32'(out_tag), 32'd1);
    setBeat(16'($urandom), 3'($urandom_range(0, 5)), 5'd3);
    tick();
    check("bp_ready_still_full", 32'(in_ready), 32'd0);
    check("bp_tag_stall2", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    for (int t = 3; t <= 6; t++) begin
      offer(16'($urandom), 3'($urandom_range(0, 5)), 5'(t));
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Test 4: streaming accept and drain on the same edge
    vldCount = 0;
    rdyZero  = 0;
    for (int i = 0; i < 20; i++) begin
      setBeat(16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
      if (!in_ready) rdyZero++;
      tick();
      if (out_valid) vldCount++;
    end
    in_valid = 1'b0;
    check("stream_valid_cycles", 32'(vldCount), 32'd20);
    check("stream_ready_drops", 32'(rdyZero), 32'd0);
    repeat (3) tick();
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Test 5: flush with two beats held and a beat offered
    out_ready = 1'b0;
    setBeat(16'($urandom), 3'd1, 5'd11);
    tick();
    setBeat(16'($urandom), 3'd2, 5'd12);
    tick();
    setBeat(16'($urandom), 3'd0, 5'd13);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    setBeat(16'hbeef, 3'd4, 5'd14);
    tick();
    in_valid = 1'b0;
    check("flush_next_valid", 32'(out_valid), 32'd1);
    check("flush_next_tag", 32'(out_tag), 32'd14);
    tick();
    check("flush_sb_empty", 32'(sb.size()), 32'd0);

    // Test 6: reset while stalled with two beats held
    out_ready = 1'b0;
    setBeat(16'h1234, 3'd0, 5'd9);
    tick();
    setBeat(16'h5678, 3'd1, 5'd10);
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check("rstmid_in_ready", 32'(in_ready), 32'd0);
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_out_data", out_data, 32'd0);
    check("rstmid_out_tag", 32'(out_tag), 32'd0);
    check("rstmid_out_err", 32'(out_err), 32'd0);
    reset = 1'b0;
    tick();
    check("rstmid_ready_after", 32'(in_ready), 32'd1);
    check("rstmid_valid_after", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // Randomised traffic with back-pressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        setBeat(16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("rand_idle_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
